// File: rtl/sr_driver.sv
// Pulse-driven controller for an external SR flip-flop: issues a set/reset pulse,
// waits for Q feedback to match, then reports done or a timeout error.
module sr_driver #(
  parameter int unsigned PULSE_LEN = 1,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  input  logic       q_fb,
  output logic       S,
  output logic       R,
  output logic       done,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {StIdle, StPulse, StWait, StResp} state_e;

  localparam logic [3:0] PulseLast = 4'(PULSE_LEN - 1);
  localparam logic [7:0] WaitLast  = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic       target_q;
  logic [3:0] pcnt_q;
  logic [7:0] wcnt_q;
  logic       op_tgt;

  // Target level for set/reset/toggle; toggle inverts the feedback seen at acceptance.
  assign op_tgt    = (req_op == 2'b01) | ((req_op == 2'b11) & ~q_fb);
  assign req_ready = (state_q == StIdle) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      target_q <= 1'b0;
      pcnt_q   <= '0;
      wcnt_q   <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          S <= 1'b0;
          R <= 1'b0;
          if (req_valid) begin
            if (req_op == 2'b00) begin
              done    <= 1'b1;
              state_q <= StResp;
            end else begin
              // S and R come from one bit and its complement, so they can never overlap.
              target_q <= op_tgt;
              S        <= op_tgt;
              R        <= ~op_tgt;
              pcnt_q   <= '0;
              state_q  <= StPulse;
            end
          end
        end
        StPulse: begin
          if (pcnt_q == PulseLast) begin
            S       <= 1'b0;
            R       <= 1'b0;
            wcnt_q  <= '0;
            state_q <= StWait;
          end else begin
            pcnt_q <= pcnt_q + 4'd1;
          end
        end
        StWait: begin
          S <= 1'b0;
          R <= 1'b0;
          if (q_fb == target_q) begin
            done    <= 1'b1;
            state_q <= StResp;
          end else if (wcnt_q == WaitLast) begin
            err     <= 1'b1;
            state_q <= StResp;
            if (err_cnt != 8'hff) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        StResp: begin
          S       <= 1'b0;
          R       <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          S       <= 1'b0;
          R       <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_driver.sv
// Bench for sr_driver: SR flop model on q_fb, a per-command timeline scoreboard checked
// every cycle, plus directed scenarios with hand-computed latencies.
module tb_sr_driver;

  localparam int unsigned PL = 1;
  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       q_fb;
  logic       S;
  logic       R;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // 0: ideal SR flop, 1: feedback stuck at 0, 2: feedback stuck at 1
  int   mode = 0;
  logic q    = 1'b0;

  logic [3:0] sched[$];  // expected {S,R,done,err} for each busy cycle
  int         mcnt = 0;

  sr_driver #(.PULSE_LEN(PL), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_ready(req_ready),
    .q_fb     (q_fb),
    .S        (S),
    .R        (R),
    .done     (done),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (S) q <= 1'b1;
    else if (R) q <= 1'b0;
  end

  assign q_fb = (mode == 0) ? q : (mode == 2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every negedge pops the expected outputs for the cycle just started.
  always @(negedge clk) begin
    logic [3:0] ev;
    logic       exp_ready;
    logic       tgt;
    logic       fin;
    if (!rst) begin
      chk("rst_S", S, 0);
      chk("rst_R", R, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_errcnt", err_cnt, 0);
      chk("rst_ready", req_ready, 0);
      sched.delete();
      mcnt = 0;
    end else begin
      exp_ready = (sched.size() == 0);
      ev = exp_ready ? 4'b0000 : sched.pop_front();
      if (ev[0] && mcnt < 255) mcnt++;
      chk("S", S, ev[3]);
      chk("R", R, ev[2]);
      chk("done", done, ev[1]);
      chk("err", err, ev[0]);
      chk("ready", req_ready, exp_ready);
      chk("err_cnt", err_cnt, mcnt);
      chk("excl", S & R, 0);
      if (req_valid && exp_ready) begin
        if (req_op == 2'b00) begin
          sched.push_back(4'b0010);
        end else begin
          tgt = (req_op == 2'b01) ? 1'b1 : (req_op == 2'b10) ? 1'b0 : ~q_fb;
          fin = (mode == 0) ? tgt : (mode == 2);
          for (int i = 0; i < PL; i++) sched.push_back({tgt, ~tgt, 2'b00});
          for (int i = 0; i < ((fin == tgt) ? 1 : TO); i++) sched.push_back(4'b0000);
          sched.push_back((fin == tgt) ? 4'b0010 : 4'b0001);
        end
      end
    end
  end

  // Issue one command from idle; report cycle of done/err counted from the accept edge.
  task automatic issue(input logic [1:0] op, output int cyc, output bit d, output bit e,
                       output int scyc, output int rcyc);
    @(posedge clk);
    #2;
    req_valid = 1'b1;
    req_op    = op;
    cyc = 0; d = 0; e = 0; scyc = 0; rcyc = 0;
    for (int i = 0; i < 64 && !(d || e); i++) begin
      @(posedge clk);
      #1;
      cyc = i + 1;
      if (S) scyc++;
      if (R) rcyc++;
      if (done) d = 1;
      if (err) e = 1;
      #1;
      if (i == 0) req_valid = 1'b0;
    end
    if (!(d || e)) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    int  cyc, sc, rc, nerr;
    bit  d, e;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Set then reset with an ideal flop
    issue(2'b01, cyc, d, e, sc, rc);
    chk("set_cyc", cyc, 3);
    chk("set_done", d, 1);
    chk("set_spulse", sc, 1);
    chk("set_q", q_fb, 1);
    issue(2'b10, cyc, d, e, sc, rc);
    chk("rst_cyc", cyc, 3);
    chk("rst_rpulse", rc, 1);
    chk("rst_q", q_fb, 0);

    // Toggle twice, then hold
    issue(2'b11, cyc, d, e, sc, rc);
    chk("tog1_s", sc, 1);
    chk("tog1_q", q_fb, 1);
    issue(2'b11, cyc, d, e, sc, rc);
    chk("tog2_r", rc, 1);
    chk("tog2_done", d, 1);
    chk("tog2_q", q_fb, 0);
    issue(2'b00, cyc, d, e, sc, rc);
    chk("hold_cyc", cyc, 1);
    chk("hold_done", d, 1);
    chk("hold_sr", sc + rc, 0);

    // Set against feedback stuck low: timeout
    mode = 1;
    issue(2'b01, cyc, d, e, sc, rc);
    chk("to_cyc", cyc, 10);
    chk("to_err", e, 1);
    chk("to_nodone", d, 0);
    chk("to_cnt", err_cnt, 1);

    // Reset during the set pulse
    mode = 0;
    @(posedge clk);
    #2 req_valid = 1'b1; req_op = 2'b01;
    @(posedge clk);
    #2 req_valid = 1'b0;
    chk("mid_S_pre", S, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_S", S, 0);
    chk("mid_cnt", err_cnt, 0);
    chk("mid_ready", req_ready, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("mid_ready_rel", req_ready, 1);

    // Random ops with random valid, including while busy
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (req_ready && $urandom_range(0, 7) == 0) mode = $urandom_range(0, 2);
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = 2'($urandom_range(0, 3));
    end

    // 300 back-to-back timeouts
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    wait (req_ready);
    @(posedge clk);
    #2;
    mode = 1; req_op = 2'b01; req_valid = 1'b1;
    nerr = 0;
    for (int i = 0; i < 5000 && nerr < 300; i++) begin
      @(posedge clk);
      #1;
      if (err) nerr++;
    end
    chk("sat_nerr", nerr, 300);
    chk("sat_cnt", err_cnt, 255);
    #1 req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("sat_hold", err_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
